// File: rtl/mem_req_router.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_router
//  Brief    : Decodes MEM-stage load/store requests against programmable
//             address windows, forwards them to one slave over a valid/ready
//             channel and returns the slave response, an access fault or a
//             timeout error to the core.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module mem_req_router #(
   parameter int                          NUM_REGIONS    = 2,
   parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE    = {32'h0000_2400, 32'h0000_1000},
   parameter logic [NUM_REGIONS*32-1:0]   REGION_SIZE    = {32'h0000_0010, 32'h0000_0400},
   parameter logic [NUM_REGIONS-1:0]      WORD_ONLY      = 2'b10,
   parameter int                          TIMEOUT_CYCLES = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   // core request / response
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [31:0]                 req_addr,
   input  logic                        req_we,
   input  logic [1:0]                  req_size,
   input  logic [31:0]                 req_wdata,
   input  logic [3:0]                  req_wstrb,
   output logic                        rsp_valid,
   output logic [31:0]                 rsp_rdata,
   output logic                        rsp_err,
   // slave side
   output logic [NUM_REGIONS-1:0]      slv_valid,
   input  logic [NUM_REGIONS-1:0]      slv_ready,
   output logic [31:0]                 slv_addr,
   output logic                        slv_we,
   output logic [31:0]                 slv_wdata,
   output logic [3:0]                  slv_wstrb,
   input  logic [NUM_REGIONS-1:0]      slv_rvalid,
   input  logic [NUM_REGIONS*32-1:0]   slv_rdata,
   input  logic [NUM_REGIONS-1:0]      slv_rerr
);

   localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   // Timeout fires in the cycle whose increment would reach TIMEOUT_CYCLES,
   // so exactly TIMEOUT_CYCLES cycles are spent in ISSUE+WAIT.
   localparam bit               c_TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] c_CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_RESP  = 2'd3;

   logic [1:0]             r_state;
   logic                   r_ready_en;
   logic [31:0]            r_addr;
   logic                   r_we;
   logic [31:0]            r_wdata;
   logic [3:0]             r_wstrb;
   logic [SEL_W-1:0]       r_sel;
   logic [31:0]            r_rdata;
   logic                   r_err;
   logic [CNT_W-1:0]       r_cnt;

   logic [NUM_REGIONS-1:0] w_hit;
   logic                   w_any_hit;
   logic [SEL_W-1:0]       w_sel;
   logic [31:0]            w_base;
   logic                   w_align_bad;
   logic                   w_word_bad;
   logic                   w_fault;
   logic                   w_accept;
   logic                   w_timeout;
   logic                   w_sel_ready;
   logic                   w_sel_rvalid;
   logic                   w_sel_rerr;
   logic [31:0]            w_sel_rdata;
   logic [NUM_REGIONS-1:0] w_slv_valid;

   // Window match per region, widened to 33 bits so top-of-memory never wraps
   generate
      for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
         assign w_hit[gi] = ({1'b0, req_addr} >= {1'b0, REGION_BASE[32*gi +: 32]}) &&
                            (({1'b0, req_addr} - {1'b0, REGION_BASE[32*gi +: 32]}) <
                             {1'b0, REGION_SIZE[32*gi +: 32]});
      end
   endgenerate

   // Priority select: scan downward so the lowest matching index wins
   always_comb begin
      w_sel     = '0;
      w_any_hit = 1'b0;
      w_base    = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_sel     = SEL_W'(i);
            w_any_hit = 1'b1;
            w_base    = REGION_BASE[32*i +: 32];
         end
      end
   end

   // Size/alignment legality of the incoming request
   always_comb begin
      w_align_bad = 1'b0;
      case (req_size)
         2'b00:   w_align_bad = 1'b0;
         2'b01:   w_align_bad = req_addr[0];
         2'b10:   w_align_bad = (req_addr[1:0] != 2'b00);
         default: w_align_bad = 1'b1;
      endcase
   end

   assign w_word_bad = WORD_ONLY[w_sel] && (req_size != 2'b10);
   assign w_fault    = !w_any_hit || w_align_bad || w_word_bad;

   assign req_ready  = r_ready_en && (r_state == c_IDLE);
   assign w_accept   = req_valid && req_ready;
   assign w_timeout  = c_TO_EN && (r_cnt == c_CNT_LAST);

   // Pick the handshake/response lines of the latched slave only
   always_comb begin
      w_sel_ready  = 1'b0;
      w_sel_rvalid = 1'b0;
      w_sel_rerr   = 1'b0;
      w_sel_rdata  = '0;
      w_slv_valid  = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (r_sel == SEL_W'(i)) begin
            w_sel_ready    = slv_ready[i];
            w_sel_rvalid   = slv_rvalid[i];
            w_sel_rerr     = slv_rerr[i];
            w_sel_rdata    = slv_rdata[32*i +: 32];
            w_slv_valid[i] = (r_state == c_ISSUE);
         end
      end
   end

   // Transaction FSM with request/response latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_ready_en <= 1'b0;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_sel      <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_addr  <= req_addr - w_base;
                  r_we    <= req_we;
                  r_wdata <= req_wdata;
                  r_wstrb <= req_wstrb;
                  r_sel   <= w_sel;
                  r_rdata <= '0;
                  r_err   <= w_fault;
                  r_state <= w_fault ? c_RESP : c_ISSUE;
               end
            end
            c_ISSUE: begin
               if (w_timeout) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_state <= c_RESP;
               end else if (w_sel_ready) begin
                  r_state <= c_WAIT;
               end
            end
            c_WAIT: begin
               // A response arriving in the last allowed cycle still counts
               if (w_sel_rvalid) begin
                  r_rdata <= r_we ? 32'h0 : w_sel_rdata;
                  r_err   <= w_sel_rerr;
                  r_state <= c_RESP;
               end else if (w_timeout) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_state <= c_RESP;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Saturating timeout counter, restarted on every accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if (((r_state == c_ISSUE) || (r_state == c_WAIT)) && (r_cnt != c_CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign rsp_valid = (r_state == c_RESP);
   assign rsp_rdata = rsp_valid ? r_rdata : 32'h0;
   assign rsp_err   = rsp_valid && r_err;

   assign slv_valid = w_slv_valid;
   assign slv_addr  = r_addr;
   assign slv_we    = r_we;
   assign slv_wdata = r_wdata;
   assign slv_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_req_router
//  Brief    : Directed self-checking bench for mem_req_router (default
//             regions, 8-cycle timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_router;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  slv_valid;
   logic [1:0]  slv_ready;
   logic [31:0] slv_addr;
   logic        slv_we;
   logic [31:0] slv_wdata;
   logic [3:0]  slv_wstrb;
   logic [1:0]  slv_rvalid;
   logic [63:0] slv_rdata;
   logic [1:0]  slv_rerr;

   int n_total = 0;
   int n_bad   = 0;

   mem_req_router #(
      .NUM_REGIONS    (2),
      .REGION_BASE    ({32'h0000_2400, 32'h0000_1000}),
      .REGION_SIZE    ({32'h0000_0010, 32'h0000_0400}),
      .WORD_ONLY      (2'b10),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .slv_valid  (slv_valid),
      .slv_ready  (slv_ready),
      .slv_addr   (slv_addr),
      .slv_we     (slv_we),
      .slv_wdata  (slv_wdata),
      .slv_wstrb  (slv_wstrb),
      .slv_rvalid (slv_rvalid),
      .slv_rdata  (slv_rdata),
      .slv_rerr   (slv_rerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; returns at the next falling edge
   // (first cycle after the accept) with req_valid dropped.
   task automatic send(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [3:0] ws);
      check("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = a;
      req_we    = we;
      req_size  = sz;
      req_wdata = wd;
      req_wstrb = ws;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Faulting request: error pulse in the cycle right after accept, no slave touched
   task automatic fault_case(input string tag, input logic [31:0] a, input logic [1:0] sz);
      send(a, 1'b0, sz, 32'h0, 4'h0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_rsp_err"},   32'(rsp_err),   32'd1);
      check({tag, "_rsp_rdata"}, rsp_rdata,      32'h0);
      check({tag, "_slv_valid"}, 32'(slv_valid), 32'd0);
      @(negedge clk);
      check({tag, "_rsp_gone"},  32'(rsp_valid), 32'd0);
      check({tag, "_no_slv"},    32'(slv_valid), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_we     = 1'b0;
      req_size   = 2'b00;
      req_wdata  = '0;
      req_wstrb  = '0;
      slv_ready  = '0;
      slv_rvalid = '0;
      slv_rdata  = '0;
      slv_rerr   = '0;

      // ---- reset state ----
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_slv_valid", 32'(slv_valid), 32'd0);
      check("rst_slv_addr",  slv_addr,       32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);

      // ---- 1: word load 0x1004, slave0 ready at once, data next cycle ----
      slv_ready = 2'b01;
      send(32'h0000_1004, 1'b0, 2'b10, 32'h0, 4'h0);
      check("t1_slv_valid", 32'(slv_valid), 32'd1);
      check("t1_slv_addr",  slv_addr,       32'h4);
      check("t1_slv_we",    32'(slv_we),    32'd0);
      check("t1_rsp_early", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      slv_ready        = 2'b00;
      check("t1_valid_drop", 32'(slv_valid), 32'd0);
      slv_rvalid       = 2'b01;
      slv_rdata[31:0]  = 32'hDEAD_BEEF;
      @(negedge clk);
      slv_rvalid = 2'b00;
      check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t1_rsp_rdata", rsp_rdata,      32'hDEAD_BEEF);
      check("t1_rsp_err",   32'(rsp_err),   32'd0);
      @(negedge clk);
      check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
      check("t1_rdata_idle", rsp_rdata,     32'h0);

      // ---- 2: word store 0x240C, slave1 stalls 3 cycles ----
      send(32'h0000_240C, 1'b1, 2'b10, 32'h1234_5678, 4'hF);
      for (int k = 0; k < 3; k++) begin
         check("t2_slv_valid_hold", 32'(slv_valid), 32'd2);
         check("t2_slv_addr_hold",  slv_addr,       32'hC);
         check("t2_slv_wdata_hold", slv_wdata,      32'h1234_5678);
         @(negedge clk);
      end
      check("t2_slv_valid_4th", 32'(slv_valid), 32'd2);
      check("t2_slv_wstrb",     32'(slv_wstrb), 32'hF);
      check("t2_slv_we",        32'(slv_we),    32'd1);
      slv_ready = 2'b10;
      @(negedge clk);
      slv_ready          = 2'b00;
      check("t2_valid_drop", 32'(slv_valid), 32'd0);
      slv_rvalid         = 2'b10;
      slv_rdata[63:32]   = 32'hFFFF_FFFF;
      @(negedge clk);
      slv_rvalid = 2'b00;
      check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t2_rsp_rdata", rsp_rdata,      32'h0);
      check("t2_rsp_err",   32'(rsp_err),   32'd0);
      @(negedge clk);

      // ---- 3 + boundaries: faulting requests ----
      fault_case("byte_word_only", 32'h0000_2400, 2'b00);
      fault_case("misaligned_word", 32'h0000_1002, 2'b10);
      fault_case("misaligned_half", 32'h0000_1001, 2'b01);
      fault_case("illegal_size",    32'h0000_1000, 2'b11);
      fault_case("unmapped",        32'h0000_3000, 2'b10);
      fault_case("past_region0",    32'h0000_1400, 2'b10);
      fault_case("top_no_wrap",     32'hFFFF_FFFC, 2'b10);

      // ---- 6: last word of region 0; foreign RVALID during WAIT ignored ----
      slv_ready = 2'b01;
      send(32'h0000_13FC, 1'b0, 2'b10, 32'h0, 4'h0);
      check("t6_slv_valid", 32'(slv_valid), 32'd1);
      check("t6_slv_addr",  slv_addr,       32'h3FC);
      @(negedge clk);
      slv_ready        = 2'b00;
      slv_rvalid       = 2'b10;
      slv_rerr         = 2'b10;
      slv_rdata[63:32] = 32'hBAD0_BAD0;
      @(negedge clk);
      check("t6_foreign_ignored", 32'(rsp_valid), 32'd0);
      slv_rerr        = 2'b00;
      slv_rvalid      = 2'b01;
      slv_rdata[31:0] = 32'h0A0B_0C0D;
      @(negedge clk);
      slv_rvalid = 2'b00;
      check("t6_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t6_rsp_rdata", rsp_rdata,      32'h0A0B_0C0D);
      check("t6_rsp_err",   32'(rsp_err),   32'd0);
      @(negedge clk);

      // ---- slave error on a store propagates ----
      slv_ready = 2'b01;
      send(32'h0000_1010, 1'b1, 2'b10, 32'hCAFE_F00D, 4'h3);
      @(negedge clk);
      slv_ready       = 2'b00;
      slv_rvalid      = 2'b01;
      slv_rerr        = 2'b01;
      slv_rdata[31:0] = 32'h7777_7777;
      @(negedge clk);
      slv_rvalid = 2'b00;
      slv_rerr   = 2'b00;
      check("serr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("serr_rsp_err",   32'(rsp_err),   32'd1);
      check("serr_rsp_rdata", rsp_rdata,      32'h0);
      @(negedge clk);

      // ---- 4: timeout after 8 cycles in ISSUE+WAIT ----
      slv_ready = 2'b01;
      send(32'h0000_1000, 1'b0, 2'b10, 32'h0, 4'h0);
      check("t4_slv_valid", 32'(slv_valid), 32'd1);
      @(negedge clk);
      slv_ready = 2'b00;
      for (int k = 2; k <= 8; k++) begin
         check("t4_no_rsp_yet", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t4_rsp_err",   32'(rsp_err),   32'd1);
      check("t4_rsp_rdata", rsp_rdata,      32'h0);
      @(negedge clk);
      check("t4_rsp_pulse", 32'(rsp_valid), 32'd0);
      slv_rvalid      = 2'b01;
      slv_rdata[31:0] = 32'h5555_5555;
      @(negedge clk);
      slv_rvalid = 2'b00;
      check("t4_late_ignored", 32'(rsp_valid), 32'd0);
      check("t4_idle_ready",   32'(req_ready), 32'd1);

      // ---- 5a: reset while in ISSUE drops SLV_VALID at once ----
      send(32'h0000_1004, 1'b0, 2'b10, 32'h0, 4'h0);
      check("t5a_slv_valid", 32'(slv_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5a_slv_valid_rst", 32'(slv_valid), 32'd0);
      check("t5a_ready_rst",     32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- 5b: reset while in WAIT, then a normal load ----
      slv_ready = 2'b01;
      send(32'h0000_1000, 1'b0, 2'b10, 32'h0, 4'h0);
      @(negedge clk);
      slv_ready = 2'b00;
      rst_n     = 1'b0;
      #1;
      check("t5b_slv_valid_rst", 32'(slv_valid), 32'd0);
      check("t5b_rsp_valid_rst", 32'(rsp_valid), 32'd0);
      check("t5b_ready_rst",     32'(req_ready), 32'd0);
      @(negedge clk);
      check("t5b_no_rsp", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("t5b_ready_at_release", 32'(req_ready), 32'd0);
      @(negedge clk);
      slv_ready = 2'b01;
      send(32'h0000_1000, 1'b0, 2'b10, 32'h0, 4'h0);
      check("t5b_slv_valid", 32'(slv_valid), 32'd1);
      check("t5b_slv_addr",  slv_addr,       32'h0);
      @(negedge clk);
      slv_ready       = 2'b00;
      slv_rvalid      = 2'b01;
      slv_rdata[31:0] = 32'h1122_3344;
      @(negedge clk);
      slv_rvalid = 2'b00;
      check("t5b_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t5b_rsp_rdata", rsp_rdata,      32'h1122_3344);
      check("t5b_rsp_err",   32'(rsp_err),   32'd0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_req_router.md
Name: mem_req_router

Overview:
Parametrised successor to the MEM-stage address router. It decodes each load/store request against NUM_REGIONS programmable address windows and forwards it to the selected slave over a valid/ready request channel. It then waits for the slave's response and returns data or an access fault to the core. The block sits between the MEM pipeline stage and the data-side slaves (DMEM, AXI-Lite bridge, future peripherals), and adds alignment checking, per-region word-only enforcement, an unmapped-address fault and a response timeout.

Parameters:
NUM_REGIONS, 2, number of slave regions (1..8).
REGION_BASE, {32'h0000_2400, 32'h0000_1000}, packed NUM_REGIONS*32; region i base at [32*i +: 32].
REGION_SIZE, {32'h0000_0010, 32'h0000_0400}, packed NUM_REGIONS*32; region i byte size; must be nonzero.
WORD_ONLY, 2'b10, bit i set: region i accepts word accesses only.
TIMEOUT_CYCLES, 256, cycles allowed in ISSUE+WAIT before a forced error response; 0 disables the timeout.

Ports:
CLK  in  1  system clock; all state updates on the rising edge.
RST_N  in  1  asynchronous, active-low reset.
REQ_VALID  in  1  core request valid.
REQ_READY  out  1  router can accept a request.
REQ_ADDR  in  32  byte address (ALU result).
REQ_WE  in  1  1 = store, 0 = load.
REQ_SIZE  in  2  00 byte, 01 half, 10 word; 11 is illegal and faults.
REQ_WDATA  in  32  store data, already lane-aligned.
REQ_WSTRB  in  4  byte strobes.
RSP_VALID  out  1  one-cycle response pulse.
RSP_RDATA  out  32  raw load word; 0 for stores and faults.
RSP_ERR  out  1  access fault or timeout.
SLV_VALID  out  NUM_REGIONS  one-hot request valid.
SLV_READY  in  NUM_REGIONS  per-slave request accept.
SLV_ADDR  out  32  address minus REGION_BASE[sel].
SLV_WE  out  1  latched REQ_WE.
SLV_WDATA  out  32  latched REQ_WDATA.
SLV_WSTRB  out  4  latched REQ_WSTRB.
SLV_RVALID  in  NUM_REGIONS  per-slave response valid.
SLV_RDATA  in  NUM_REGIONS*32  per-slave read data, slave i at [32*i +: 32].
SLV_RERR  in  NUM_REGIONS  per-slave error.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state = IDLE.
  - All outputs are 0, including REQ_READY. REQ_READY rises in the first cycle after release.
  - Latched fields and the timeout counter clear. An in-flight transaction is abandoned and SLV_VALID drops immediately.
- Decode (combinational, on REQ_ADDR):
  - hit[i] = (ADDR >= BASE[i]) && (ADDR - BASE[i] < SIZE[i]). The compare is 33-bit safe, so there is no wrap at 0xFFFF_FFFF.
  - On overlapping regions the lowest index wins.
  - fault = no hit, or REQ_SIZE=11, or half with ADDR[0]=1, or word with ADDR[1:0]!=0, or WORD_ONLY[sel] with size != word.
- Handshake: a request is accepted on REQ_VALID && REQ_READY. REQ_READY = (state==IDLE).
- On accept, ADDR, WE, WDATA, WSTRB, sel and fault are latched, then:
  - fault: go to RESP with err=1; no slave is touched.
  - otherwise: go to ISSUE.
- ISSUE:
  - SLV_VALID[sel]=1 and all SLV_* fields hold steady.
  - On SLV_READY[sel], go to WAIT; SLV_VALID drops the next cycle.
- WAIT:
  - On SLV_RVALID[sel], capture SLV_RDATA[sel] (forced to 0 on stores) and SLV_RERR[sel], then go to RESP.
  - SLV_RVALID and SLV_RDATA of non-selected slaves are ignored.
  - A slave must not assert RVALID in the same cycle as READY; a response in that cycle is ignored.
- RESP: RSP_VALID=1 for exactly one cycle with the captured RSP_RDATA and RSP_ERR, then back to IDLE.
- Timeout:
  - The counter clears on accept and increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES: go to RESP with err=1 and rdata=0, and drop SLV_VALID.
  - A late RVALID from that slave is ignored.
  - The counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- Latency:
  - Fault response: accept cycle N, RSP_VALID in cycle N+1.
  - Best-case slave access (READY in the first ISSUE cycle, RVALID in the next): RSP_VALID in cycle N+3.
- One outstanding transaction only. A new request can be accepted in the cycle after the RSP_VALID pulse.

Test Plan:
1. Word load 0x0000_1004, slave0 READY at once, RVALID the next cycle with RDATA 0xDEADBEEF → SLV_VALID=2'b01, SLV_ADDR=0x4; RSP_VALID 3 cycles after accept, RSP_RDATA=0xDEADBEEF, RSP_ERR=0.
2. Word store 0x0000_240C, WDATA 0x1234_5678, WSTRB 4'hF, slave1 READY after 3 stall cycles → SLV_VALID=2'b10 held 4 cycles with stable SLV_ADDR=0xC and SLV_WDATA; RSP_RDATA=0, RSP_ERR=0.
3. Faults:
   - Byte load at 0x2400 (WORD_ONLY region) → RSP_ERR=1 in cycle N+1, no SLV_VALID.
   - Word load at 0x1002 (misaligned) → RSP_ERR=1 in cycle N+1, no SLV_VALID.
   - Load at 0x3000 (unmapped) → RSP_ERR=1 in cycle N+1, no SLV_VALID.
4. TIMEOUT_CYCLES=8, slave0 never asserts RVALID → RSP_VALID with RSP_ERR=1 at accept+9; a later RVALID from slave0 produces no response.
5. RST_N asserted while in WAIT → SLV_VALID, RSP_VALID and REQ_READY are 0 immediately; after release, a normal load to 0x1000 completes correctly.
6. Boundaries: addresses 0x13FC (hit region 0), 0x1400 (fault) and 0xFFFF_FFFC (fault, no wrap); a SLV_RVALID from slave1 during a slave0 WAIT is ignored.
